pcileech_com_arbiter: RTL
=========================

# pcileech_com_arbiter

Arbitrates the host command channel between the two transports present on the board, FT601 USB and the RMII/UDP Ethernet path, so that exactly one of them owns `pcileech_fifo`'s COM port at a time. It sits between the two transport cores and the FIFO controller's `IfComToFifo` side.
- It grants ownership on first inbound traffic.
- It forwards that owner's 64-bit command words and routes 256-bit responses back only to the owner.
- It releases ownership on idle timeout or on a forced release.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 100000000: idle cycles before ownership is released (1 s at 100 MHz).
- `TMR_W`, 27: idle-timer width; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ft_dout`, `ft_dout_valid`  in  64, 1  command words from the FT601 core.
- `eth_dout`, `eth_dout_valid`  in  64, 1  command words from the UDP core.
- `com_dout`, `com_dout_valid`  out  64, 1  registered command words to the FIFO controller.
- `com_din`, `com_din_wr_en`  in  256, 1  responses from the FIFO controller.
- `com_din_ready`  out  1  response backpressure to the FIFO controller.
- `ft_din`, `ft_din_wr_en`  out  256, 1  responses to the FT601 core.
- `ft_din_ready`  in  1  FT601 core ready.
- `eth_din`, `eth_din_wr_en`  out  256, 1  responses to the UDP core.
- `eth_din_ready`  in  1  UDP core ready.
- `release_req`  in  1  one-cycle forced release, e.g. on config reload.
- `owner`  out  2  current owner: 0 = NONE, 1 = FT, 2 = ETH.
- `drop_cnt`  out  16  saturating count of dropped non-owner command words.

## Operation
States are IDLE, OWN_FT and OWN_ETH. The state register drives `owner` directly.

- **IDLE:**
  - On the first cycle either `*_dout_valid` is high, grant that source and forward its word.
  - If both are high in the same cycle, grant the source that was not the last owner. `last_owner` resets to ETH, so FT wins the first tie.
  - The losing word in a tie is dropped and counted.
- **OWN_x:**
  - Owner words are forwarded.
  - Every valid non-owner word is dropped and increments `drop_cnt`, which saturates at 0xFFFF.
- **Responses:**
  - `ft_din` and `eth_din` always carry `com_din`.
  - `x_din_wr_en = com_din_wr_en & (owner == x)`.
  - `com_din_ready` = owner's `din_ready`; it is 1 in IDLE.
  - `com_din_wr_en` in IDLE is discarded silently and not counted.
- **Idle timer:**
  - Activity is an owner `dout_valid` or `com_din_wr_en` while owned. Activity clears the timer.
  - With no activity, the timer increments each owned cycle.
  - When the timer reaches TIMEOUT_CYCLES-1 with no activity that cycle, go to IDLE and record `last_owner`.
  - If activity and the terminal count occur in the same cycle, activity wins and the owner is kept.
- **`release_req`:**
  - Forces IDLE on the next edge and records `last_owner`.
  - It has priority over everything else. Inbound words in that cycle are discarded and not counted, and no grant happens that cycle.
  - In IDLE it has no effect.

## Timing
- **Reset values:**
  - `owner` = 0.
  - `com_dout` = 0 and `com_dout_valid` = 0.
  - `drop_cnt` = 0.
  - All `*_wr_en` = 0.
  - `com_din_ready` = 1.
  - Timer = 0, `last_owner` = ETH.
- **Command path:** 1-cycle latency. A word valid at edge N appears on `com_dout`/`com_dout_valid` after edge N, including the granting word in IDLE. `com_dout` holds its last value when not valid.
- **Response path:** combinational from `owner`, so there is zero-latency gating. `owner` changes only at clock edges, so no response beat is split across owners.
- **Grant:** `owner` updates after the edge that sampled the granting word.
- **Timeout:** the owner is released exactly TIMEOUT_CYCLES cycles after the last activity.
- **Mid-operation reset:** asserting `rst_n` low clears everything asynchronously, including any in-flight `com_dout_valid`.

## Structure
- Package `pcileech_com_arb_pkg`:
  - enum `com_owner_t` (NONE=0, FT=1, ETH=2).
  - localparam `DROP_CNT_MAX` = 16'hFFFF.
- Sub-module `pcileech_com_arb_timer` (parameters `TIMEOUT_CYCLES`, `TMR_W`):
  - Inputs: `clk`, `rst_n`, `enable` (owned), `activity`.
  - Output: `expire`, a one-cycle pulse.
- The top of the block contains the FSM, the command register, the response gating and the drop counter.

## Test plan
- **FT grant:** reset, then FT word 0x1122334455667788 valid for 1 cycle -> `owner`=1 next cycle, `com_dout`=0x1122334455667788 with `com_dout_valid` for exactly 1 cycle; `ft_din_wr_en` follows `com_din_wr_en`; `eth_din_wr_en` stays 0.
- **Contention:** owner FT, 3 ETH words -> none forwarded, `drop_cnt`=3; with `drop_cnt` preset by 65540 drops -> `drop_cnt` holds 0xFFFF.
- **Timeout (TIMEOUT_CYCLES=16):** last FT activity, then 15 quiet cycles -> still FT; the 16th -> `owner`=0. Activity on cycle 16 -> stays FT, timer restarts.
- **Tie after release:** owner FT, `release_req` pulse -> `owner`=0; then FT and ETH valid in the same cycle -> `owner`=2, ETH word forwarded, `drop_cnt`+1.
- **Release collision:** `release_req` and an owner word in the same cycle -> word not forwarded, `drop_cnt` unchanged, `owner`=0.
- **Async reset:** `rst_n` low mid-burst -> `com_dout_valid`, `owner` and `drop_cnt` go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pcileech_com_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// pcileech_com_arb_pkg
// Shared types and constants for the host command-channel arbiter.
//   com_owner_t  : owner encoding, also used directly as the arbiter FSM state
//                  (NONE doubles as the IDLE state).
//   CMD_W/RSP_W  : command (inbound) and response (outbound) word widths.
//   DROP_CNT_MAX : saturation value of the dropped-word counter.
// ---------------------------------------------------------------------------
package pcileech_com_arb_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    FT   = 2'd1,
    ETH  = 2'd2
  } com_owner_t;

  localparam int          CMD_W        = 64;
  localparam int          RSP_W        = 256;
  localparam int          DROP_W       = 16;
  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/pcileech_com_arbiter_if.sv
// ---------------------------------------------------------------------------
// pcileech_com_arbiter_if
// Bundles every bus signal of the command-channel arbiter.
//   master : arbiter side (consumes transport commands and FIFO responses,
//            produces the forwarded command, routed responses and status).
//   slave  : environment side (transport cores + FIFO controller).
// Signals:
//   ft_dout/_valid, eth_dout/_valid : commands from FT601 / UDP cores
//   com_dout/_valid                 : registered command to FIFO controller
//   com_din/_wr_en, com_din_ready   : responses from FIFO controller
//   ft_din/_wr_en, ft_din_ready     : responses to FT601 core
//   eth_din/_wr_en, eth_din_ready   : responses to UDP core
//   release_req                     : one-cycle forced ownership release
//   owner, drop_cnt                 : current owner, dropped-word count
// ---------------------------------------------------------------------------
interface pcileech_com_arbiter_if;
  import pcileech_com_arb_pkg::*;

  logic [CMD_W-1:0]  ft_dout;
  logic              ft_dout_valid;
  logic [CMD_W-1:0]  eth_dout;
  logic              eth_dout_valid;
  logic [CMD_W-1:0]  com_dout;
  logic              com_dout_valid;
  logic [RSP_W-1:0]  com_din;
  logic              com_din_wr_en;
  logic              com_din_ready;
  logic [RSP_W-1:0]  ft_din;
  logic              ft_din_wr_en;
  logic              ft_din_ready;
  logic [RSP_W-1:0]  eth_din;
  logic              eth_din_wr_en;
  logic              eth_din_ready;
  logic              release_req;
  logic [1:0]        owner;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    input  ft_dout, ft_dout_valid, eth_dout, eth_dout_valid,
    input  com_din, com_din_wr_en, ft_din_ready, eth_din_ready,
    input  release_req,
    output com_dout, com_dout_valid, com_din_ready,
    output ft_din, ft_din_wr_en, eth_din, eth_din_wr_en,
    output owner, drop_cnt
  );

  modport slave (
    output ft_dout, ft_dout_valid, eth_dout, eth_dout_valid,
    output com_din, com_din_wr_en, ft_din_ready, eth_din_ready,
    output release_req,
    input  com_dout, com_dout_valid, com_din_ready,
    input  ft_din, ft_din_wr_en, eth_din, eth_din_wr_en,
    input  owner, drop_cnt
  );

endinterface

// File: rtl/pcileech_com_arb_timer.sv
// ---------------------------------------------------------------------------
// pcileech_com_arb_timer
// Idle timer for the arbiter. Counts owned cycles without activity and pulses
// expire for one cycle when the count reaches TIMEOUT_CYCLES-1 in a quiet
// cycle, so release lands exactly TIMEOUT_CYCLES cycles after last activity.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : a transport currently owns the channel
//   activity   : owner command word or response beat this cycle
//   expire     : one-cycle timeout pulse
// ---------------------------------------------------------------------------
module pcileech_com_arb_timer #(
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int TMR_W          = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic activity,
  output logic expire
);

  localparam logic [TMR_W-1:0] TERM_CNT = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] tmr_q;

  // Activity in the terminal cycle suppresses expiry, so the owner is kept.
  assign expire = enable & ~activity & (tmr_q == TERM_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
    end else if (!enable || activity || expire) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_q + 1'b1;
    end
  end

endmodule

// File: rtl/pcileech_com_arbiter.sv
// ---------------------------------------------------------------------------
// pcileech_com_arbiter
// Gives exactly one transport (FT601 USB or UDP Ethernet) ownership of the
// pcileech_fifo COM port. Ownership is granted on first inbound command word,
// owner commands are forwarded through a one-cycle register, responses are
// gated combinationally to the owner only, and ownership is released on idle
// timeout or on release_req. Non-owner command words are dropped and counted.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pcileech_com_arbiter_if.master (all command/response/status
//                signals, see the interface file)
// ---------------------------------------------------------------------------
module pcileech_com_arbiter
  import pcileech_com_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int TMR_W          = 27
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pcileech_com_arbiter_if.master bus
);

  com_owner_t        state_q, state_d;
  com_owner_t        last_owner_q, last_owner_d;
  logic              fwd_vld_p0;
  logic [CMD_W-1:0]  fwd_word_p0;
  logic              drop_inc_p0;
  logic              activity;
  logic              expire;
  logic [CMD_W-1:0]  com_dout_p1;
  logic              vld_p1;
  logic [DROP_W-1:0] drop_cnt_q;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == DROP_CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Only the current owner's traffic keeps the channel alive.
  always_comb begin
    activity = 1'b0;
    unique case (state_q)
      FT:      activity = bus.ft_dout_valid  | bus.com_din_wr_en;
      ETH:     activity = bus.eth_dout_valid | bus.com_din_wr_en;
      default: activity = 1'b0;
    endcase
  end

  pcileech_com_arb_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (state_q != NONE),
    .activity (activity),
    .expire   (expire)
  );

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    fwd_vld_p0   = 1'b0;
    fwd_word_p0  = bus.ft_dout;
    drop_inc_p0  = 1'b0;
    unique case (state_q)
      NONE: begin
        // release_req has no effect here; a tie goes to the non-last owner.
        if (bus.ft_dout_valid && bus.eth_dout_valid) begin
          drop_inc_p0 = 1'b1;
          fwd_vld_p0  = 1'b1;
          if (last_owner_q == FT) begin
            state_d     = ETH;
            fwd_word_p0 = bus.eth_dout;
          end else begin
            state_d     = FT;
            fwd_word_p0 = bus.ft_dout;
          end
        end else if (bus.ft_dout_valid) begin
          state_d     = FT;
          fwd_vld_p0  = 1'b1;
          fwd_word_p0 = bus.ft_dout;
        end else if (bus.eth_dout_valid) begin
          state_d     = ETH;
          fwd_vld_p0  = 1'b1;
          fwd_word_p0 = bus.eth_dout;
        end
      end
      FT: begin
        if (bus.release_req) begin
          // Forced release swallows everything inbound this cycle.
          state_d      = NONE;
          last_owner_d = FT;
        end else begin
          fwd_vld_p0  = bus.ft_dout_valid;
          fwd_word_p0 = bus.ft_dout;
          drop_inc_p0 = bus.eth_dout_valid;
          if (expire) begin
            state_d      = NONE;
            last_owner_d = FT;
          end
        end
      end
      ETH: begin
        if (bus.release_req) begin
          state_d      = NONE;
          last_owner_d = ETH;
        end else begin
          fwd_vld_p0  = bus.eth_dout_valid;
          fwd_word_p0 = bus.eth_dout;
          drop_inc_p0 = bus.ft_dout_valid;
          if (expire) begin
            state_d      = NONE;
            last_owner_d = ETH;
          end
        end
      end
      default: state_d = NONE;
    endcase
  end

  // Stage p0 -> p1: state, command register and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= NONE;
      last_owner_q <= ETH;
      vld_p1       <= 1'b0;
      com_dout_p1  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      vld_p1       <= fwd_vld_p0;
      if (fwd_vld_p0) begin
        com_dout_p1 <= fwd_word_p0;
      end
      if (drop_inc_p0) begin
        drop_cnt_q <= sat_inc(drop_cnt_q);
      end
    end
  end

  assign bus.com_dout       = com_dout_p1;
  assign bus.com_dout_valid = vld_p1;
  assign bus.owner          = state_q;
  assign bus.drop_cnt       = drop_cnt_q;

  // Response routing is combinational from the registered owner, so a beat
  // can never straddle an ownership change.
  assign bus.ft_din        = bus.com_din;
  assign bus.eth_din       = bus.com_din;
  assign bus.ft_din_wr_en  = bus.com_din_wr_en & (state_q == FT);
  assign bus.eth_din_wr_en = bus.com_din_wr_en & (state_q == ETH);

  always_comb begin
    bus.com_din_ready = 1'b1;
    unique case (state_q)
      FT:      bus.com_din_ready = bus.ft_din_ready;
      ETH:     bus.com_din_ready = bus.eth_din_ready;
      default: bus.com_din_ready = 1'b1;
    endcase
  end

endmodule
